// File: rtl/load_writeback_stage.sv
// Load/writeback pipeline stage: retires non-loads in one cycle, waits for the
// data-memory response on loads, extracts/extends the loaded value and writes it back.
module load_writeback_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-3:0] in_addr,
  input  logic [31:0]           in_insn,
  input  logic [1:0]            in_byte_off,
  output logic                  in_ready,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  retire_valid,
  output logic [ADDR_WIDTH-3:0] retire_addr,
  output logic                  load_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_DATA = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  // Select the addressed byte/half of the response word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b010:  extract_load = d;
      3'b100:  extract_load = {24'h000000, b};
      3'b101:  extract_load = {16'h0000, h};
      default: extract_load = 32'h0000_0000;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [4:0]            rd_q, rd_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_waddr_q, rf_waddr_d;
  logic [31:0]           rf_wdata_q, rf_wdata_d;
  logic                  retire_valid_q, retire_valid_d;
  logic [ADDR_WIDTH-3:0] retire_addr_q, retire_addr_d;
  logic                  load_err_q, load_err_d;
  logic                  is_load_s;
  logic                  unused_insn_bits;

  assign unused_insn_bits = ^in_insn[31:15];

  // Illegal funct3 values under the load opcode fall through as ordinary instructions.
  always_comb begin
    is_load_s = 1'b0;
    if (in_insn[6:0] == 7'b0000011) begin
      case (in_insn[14:12])
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load_s = 1'b1;
        default:                                is_load_s = 1'b0;
      endcase
    end else begin
      is_load_s = 1'b0;
    end
  end

  // Next-state and next-output computation; pulse outputs default low every cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    rd_d           = rd_q;
    f3_d           = f3_q;
    off_d          = off_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    retire_valid_d = 1'b0;
    retire_addr_d  = retire_addr_q;
    load_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && is_load_s) begin
          state_d = WAIT_DATA;
          cnt_d   = 8'd0;
          addr_d  = in_addr;
          rd_d    = in_insn[11:7];
          f3_d    = in_insn[14:12];
          off_d   = in_byte_off;
        end else if (in_valid) begin
          retire_valid_d = 1'b1;
          retire_addr_d  = in_addr;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_DATA: begin
        // A response wins over a timeout landing in the same cycle.
        if (mem_rsp_valid) begin
          rf_we_d        = (rd_q != 5'd0);
          rf_waddr_d     = rd_q;
          rf_wdata_d     = extract_load(f3_q, off_q, mem_rsp_data);
          retire_valid_d = 1'b1;
          retire_addr_d  = addr_q;
          state_d        = IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          load_err_d     = 1'b1;
          retire_valid_d = 1'b1;
          retire_addr_d  = addr_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      addr_q         <= '0;
      rd_q           <= 5'd0;
      f3_q           <= 3'd0;
      off_q          <= 2'd0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= 32'h0000_0000;
      retire_valid_q <= 1'b0;
      retire_addr_q  <= '0;
      load_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      rd_q           <= rd_d;
      f3_q           <= f3_d;
      off_q          <= off_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      retire_valid_q <= retire_valid_d;
      retire_addr_q  <= retire_addr_d;
      load_err_q     <= load_err_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire_valid = retire_valid_q;
  assign retire_addr  = retire_addr_q;
  assign load_err     = load_err_q;

endmodule

// File: tb/tb_load_writeback_stage.sv
// Directed bench for load_writeback_stage: table of single-instruction vectors
// plus hand-written sequences for throughput, timeout and reset corner cases.
module tb_load_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [29:0] in_addr;
  logic [31:0] in_insn;
  logic [1:0]  in_byte_off;
  logic        in_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire_valid;
  logic [29:0] retire_addr;
  logic        load_err;

  int n_cmp  = 0;
  int n_fail = 0;

  load_writeback_stage #(.ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_insn(in_insn),
    .in_byte_off(in_byte_off), .in_ready(in_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_valid(retire_valid), .retire_addr(retire_addr), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [1:0]  off;
    logic [31:0] data;
    logic        is_ld;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd,
                                     input logic [6:0] opc);
    mk = {12'h000, 5'd1, f3, rd, opc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_insn       = 32'h0000_0013;
    in_byte_off   = 2'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0000_0000;
  endtask

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ALU = 7'b0110011;

  initial begin
    vecs[0]  = '{mk(3'b000, 5'd5,  OPC_LD),  2'd3, 32'h80FF_1234, 1'b1, 1'b1, 5'd5,  32'hFFFF_FF80};
    vecs[1]  = '{mk(3'b101, 5'd7,  OPC_LD),  2'd2, 32'h9ABC_0000, 1'b1, 1'b1, 5'd7,  32'h0000_9ABC};
    vecs[2]  = '{mk(3'b010, 5'd0,  OPC_LD),  2'd0, 32'h1111_2222, 1'b1, 1'b0, 5'd0,  32'h0000_0000};
    vecs[3]  = '{mk(3'b100, 5'd1,  OPC_LD),  2'd3, 32'h80FF_1234, 1'b1, 1'b1, 5'd1,  32'h0000_0080};
    vecs[4]  = '{mk(3'b001, 5'd2,  OPC_LD),  2'd1, 32'h1234_8001, 1'b1, 1'b1, 5'd2,  32'hFFFF_8001};
    vecs[5]  = '{mk(3'b001, 5'd3,  OPC_LD),  2'd3, 32'h7FFF_0000, 1'b1, 1'b1, 5'd3,  32'h0000_7FFF};
    vecs[6]  = '{mk(3'b000, 5'd4,  OPC_LD),  2'd0, 32'hAAAA_AA7F, 1'b1, 1'b1, 5'd4,  32'h0000_007F};
    vecs[7]  = '{mk(3'b100, 5'd6,  OPC_LD),  2'd1, 32'h1234_F600, 1'b1, 1'b1, 5'd6,  32'h0000_00F6};
    vecs[8]  = '{mk(3'b010, 5'd31, OPC_LD),  2'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF};
    vecs[9]  = '{mk(3'b011, 5'd8,  OPC_LD),  2'd0, 32'h5555_5555, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[10] = '{mk(3'b000, 5'd9,  OPC_ALU), 2'd0, 32'h5555_5555, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[11] = '{mk(3'b110, 5'd10, OPC_LD),  2'd2, 32'h5555_5555, 1'b0, 1'b0, 5'd0,  32'h0000_0000};

    idle_inputs();
    in_addr = 30'd0;
    rst = 1'b1;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // Table vectors: loads get their response in the first wait cycle.
    for (int i = 0; i < 12; i++) begin
      in_valid    = 1'b1;
      in_addr     = 30'h40 + 30'(i);
      in_insn     = vecs[i].insn;
      in_byte_off = vecs[i].off;
      step();
      in_valid = 1'b0;
      if (vecs[i].is_ld) begin
        chk("ld_wait_ready", {31'd0, in_ready}, 32'd0);
        chk("ld_wait_retire", {31'd0, retire_valid}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = vecs[i].data;
        step();
        mem_rsp_valid = 1'b0;
        chk("ld_rf_we", {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
        if (vecs[i].exp_we) begin
          chk("ld_rf_waddr", {27'd0, rf_waddr}, {27'd0, vecs[i].exp_waddr});
          chk("ld_rf_wdata", rf_wdata, vecs[i].exp_wdata);
        end
      end else begin
        chk("nl_rf_we", {31'd0, rf_we}, 32'd0);
      end
      chk("vec_retire_valid", {31'd0, retire_valid}, 32'd1);
      chk("vec_retire_addr", {2'd0, retire_addr}, 32'h40 + 32'(i));
      chk("vec_load_err", {31'd0, load_err}, 32'd0);
      step();
      chk("vec_pulse_end", {31'd0, retire_valid}, 32'd0);
      chk("vec_ready_back", {31'd0, in_ready}, 32'd1);
    end

    // Back-to-back non-loads retire one per cycle.
    in_valid = 1'b1;
    in_insn  = mk(3'b000, 5'd3, OPC_ALU);
    for (int k = 0; k < 3; k++) begin
      in_addr = 30'h100 + 30'(k);
      step();
      chk("b2b_retire_valid", {31'd0, retire_valid}, 32'd1);
      chk("b2b_retire_addr", {2'd0, retire_addr}, 32'h100 + 32'(k));
      chk("b2b_rf_we", {31'd0, rf_we}, 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_end", {31'd0, retire_valid}, 32'd0);

    // LB with the response three cycles after accept; an accept-cycle response is ignored.
    in_valid      = 1'b1;
    in_addr       = 30'h150;
    in_insn       = mk(3'b000, 5'd5, OPC_LD);
    in_byte_off   = 2'd3;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_0011;
    step();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("lat_ready_low", {31'd0, in_ready}, 32'd0);
      chk("lat_no_retire", {31'd0, retire_valid}, 32'd0);
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FF_1234;
    step();
    mem_rsp_valid = 1'b0;
    chk("lat_rf_we", {31'd0, rf_we}, 32'd1);
    chk("lat_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("lat_rf_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lat_retire_addr", {2'd0, retire_addr}, 32'h150);

    // Timeout: no response at all.
    in_valid    = 1'b1;
    in_addr     = 30'h200;
    in_insn     = mk(3'b010, 5'd9, OPC_LD);
    in_byte_off = 2'd0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("to_no_err", {30'd0, load_err, retire_valid}, 32'd0);
      chk("to_ready_low", {31'd0, in_ready}, 32'd0);
    end
    step();
    chk("to_load_err", {31'd0, load_err}, 32'd1);
    chk("to_retire_valid", {31'd0, retire_valid}, 32'd1);
    chk("to_rf_we", {31'd0, rf_we}, 32'd0);
    chk("to_retire_addr", {2'd0, retire_addr}, 32'h200);
    step();
    chk("to_err_pulse", {31'd0, load_err}, 32'd0);
    chk("to_ready_back", {31'd0, in_ready}, 32'd1);

    // Response exactly at counter == TIMEOUT wins.
    in_valid    = 1'b1;
    in_addr     = 30'h210;
    in_insn     = mk(3'b101, 5'd12, OPC_LD);
    in_byte_off = 2'd0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 15; k++) step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_C0DE;
    step();
    mem_rsp_valid = 1'b0;
    chk("edge_load_err", {31'd0, load_err}, 32'd0);
    chk("edge_rf_we", {31'd0, rf_we}, 32'd1);
    chk("edge_rf_wdata", rf_wdata, 32'h0000_C0DE);
    chk("edge_retire_addr", {2'd0, retire_addr}, 32'h210);

    // Reset mid-wait abandons the load; a later response is ignored.
    in_valid    = 1'b1;
    in_addr     = 30'h300;
    in_insn     = mk(3'b010, 5'd14, OPC_LD);
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("mid_rst_raddr", {2'd0, retire_addr}, 32'd0);
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    chk("post_rst_outs", {29'd0, rf_we, retire_valid, load_err}, 32'd0);
    chk("post_rst_wdata", rf_wdata, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("post_rst_quiet", {30'd0, rf_we, retire_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_writeback_stage.md
LOAD_WRITEBACK_STAGE -- requirements
Module: load_writeback_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; instruction addresses are carried word-aligned as ADDR_WIDTH-2 bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum cycles spent waiting for load data (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream (ReadMem stage) bundle valid.
REQ-006 in_addr  input  ADDR_WIDTH-2  word address of the instruction.
REQ-007 in_insn  input  32  RISC-V instruction word.
REQ-008 in_byte_off  input  2  low two bits of the load's data address.
REQ-009 in_ready  output  1  stage can accept a bundle this cycle.
REQ-010 mem_rsp_valid  input  1  data-memory read response valid.
REQ-011 mem_rsp_data  input  32  data-memory read word.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  5  destination register.
REQ-014 rf_wdata  output  32  write data.
REQ-015 retire_valid  output  1  one-cycle pulse per retired bundle.
REQ-016 retire_addr  output  ADDR_WIDTH-2  word address of retired bundle.
REQ-017 load_err  output  1  one-cycle pulse on load timeout.

Function
REQ-018 A bundle SHALL be accepted when in_valid && in_ready at a clock edge.
REQ-019 Load = in_insn[6:0]==7'b0000011 with funct3 (in_insn[14:12]) in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}; any other funct3 with load opcode SHALL be treated as a non-load.
REQ-020 FSM states: IDLE, WAIT_DATA; in_ready SHALL be 1 only in IDLE.
REQ-021 IDLE, accepted non-load: stay IDLE; next cycle retire_valid=1, retire_addr=in_addr, rf_we=0.
REQ-022 IDLE, accepted load: capture addr, rd (in_insn[11:7]), funct3, byte_off; go WAIT_DATA; clear wait counter to 0.
REQ-023 WAIT_DATA, mem_rsp_valid=1: next cycle rf_we=1 (only if rd!=0), rf_waddr=rd, rf_wdata=extracted data, retire_valid=1, retire_addr=captured addr; return IDLE.
REQ-024 Extraction: LB/LBU byte = data[8*off+7:8*off]; LH/LHU half = data[16*off[1]+15:16*off[1]] (off[0] ignored); LW full word; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-025 A response arriving in the same cycle the load is accepted (IDLE) SHALL be ignored; mem_rsp_valid in IDLE SHALL be ignored always.
REQ-026 WAIT_DATA without response: counter increments by 1 per cycle; when counter==TIMEOUT and no response, next cycle load_err=1, retire_valid=1, rf_we=0; return IDLE.
REQ-027 Response in the cycle counter==TIMEOUT SHALL take priority over timeout (normal writeback, no load_err).
REQ-028 rf_we, retire_valid, load_err SHALL be single-cycle pulses, deasserted in all other cycles; rf_waddr/rf_wdata/retire_addr hold last values when not pulsed.
REQ-029 Back-to-back non-loads SHALL retire one per cycle (throughput 1); load latency from accept to retire = (cycles to response)+1, minimum 2.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, counter=0, rf_we=0, retire_valid=0, load_err=0, rf_waddr=0, rf_wdata=0, retire_addr=0; in_ready=1 from the first edge after rst deasserts.
REQ-031 Reset asserted in WAIT_DATA SHALL abandon the load with no writeback, no retire, no load_err; a response arriving after reset release SHALL be ignored.

Verification
REQ-032 Non-loads at addr 0x100,0x101,0x102 on consecutive cycles -> retire_valid on 3 consecutive cycles with matching retire_addr, rf_we=0 throughout.
REQ-033 LB rd=5 off=3, response 3 cycles later data=0x80FF_1234 -> rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80, one cycle after response; in_ready=0 during wait.
REQ-034 LHU rd=7 off=2, data=0x9ABC_0000 -> rf_wdata=0x0000_9ABC; LW rd=0 -> retire_valid=1, rf_we=0.
REQ-035 Load, no response, TIMEOUT=15 -> load_err and retire_valid pulse exactly 17 cycles after accept, rf_we=0, in_ready returns 1; response at counter==15 instead -> normal writeback, no load_err.
REQ-036 rst asserted mid-WAIT_DATA, response given after release -> all outputs 0, no rf_we, state IDLE.
